uart_rx_cfg: RTL and testbench

//  Parametrised UART receiver, successor to the fixed 8N1 receiver. Adds configurable data

---
 rtl/uart_rx_cfg.sv | 204 ++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg - parametrised UART receiver fed by a shared oversampling tick.
//
// Frame: start(0), DATA_BITS data bits LSB first, optional parity bit,
// STOP_BITS stop bits. Each bit is sampled three times around its middle
// and decided by a 2-of-3 vote. A start bit that votes high is discarded.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   rx         asynchronous serial input, idle high
//   b_tick     one-clk strobe, OVERSAMPLE strobes per bit period
//   rx_data    last received word, held until the next rx_valid
//   rx_valid   one-clk pulse when a frame completes
//   parity_err parity mismatch in the last frame
//   frame_err  a stop bit of the last frame sampled low
//   busy       high from start detection until back in idle
module uart_rx_cfg #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 b_tick,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned   TW      = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] T_MIDM1 = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_MID   = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] T_MIDP1 = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] T_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]    B_LAST  = 4'(DATA_BITS - 1);
  localparam logic [3:0]    S_LAST  = 4'(STOP_BITS - 1);
  localparam logic          ODD     = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                 state_q, state_d;
  logic                   sync1_q, rx_s_q;
  logic [TW-1:0]          tick_q, tick_d;
  logic [3:0]             bit_q, bit_d;
  logic [2:0]             samp_q, samp_d;
  logic                   armed_q, armed_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   perr_int_q, perr_int_d;
  logic                   ferr_int_q, ferr_int_d;
  logic                   valid_q, valid_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   vote_live;
  logic                   vote_bit;
  logic                   ferr_now;

  // vote_live is used on the MID+1 tick itself, where the third sample is
  // still on rx_s and not yet in samp_q.
  assign vote_live = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
  assign vote_bit  = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
  assign ferr_now  = ferr_int_q | ~vote_live;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= rx;
      rx_s_q  <= sync1_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    samp_d     = samp_q;
    armed_d    = armed_q;
    shift_d    = shift_q;
    data_d     = data_q;
    perr_int_d = perr_int_q;
    ferr_int_d = ferr_int_q;
    valid_d    = 1'b0;
    perr_d     = perr_q;
    ferr_d     = ferr_q;

    if (b_tick) begin
      if (state_q != S_IDLE) begin
        if (tick_q == T_MIDM1) samp_d[0] = rx_s_q;
        if (tick_q == T_MID)   samp_d[1] = rx_s_q;
        if (tick_q == T_MIDP1) samp_d[2] = rx_s_q;
        tick_d = (tick_q == T_LAST) ? '0 : tick_q + 1'b1;
      end

      unique case (state_q)
        S_IDLE: begin
          tick_d = '0;
          if (rx_s_q) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            state_d    = S_START;
            perr_int_d = 1'b0;
            ferr_int_d = 1'b0;
          end
        end
        S_START: begin
          if (tick_q == T_MIDP1 && vote_live) begin
            state_d = S_IDLE;
            tick_d  = '0;
          end else if (tick_q == T_LAST) begin
            state_d = S_DATA;
            bit_d   = '0;
          end
        end
        S_DATA: begin
          if (tick_q == T_LAST) begin
            shift_d = {vote_bit, shift_q[DATA_BITS-1:1]};
            if (bit_q == B_LAST) begin
              state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
              bit_d   = '0;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end
        end
        S_PARITY: begin
          if (tick_q == T_LAST) begin
            perr_int_d = vote_bit ^ (^shift_q) ^ ODD;
            state_d    = S_STOP;
            bit_d      = '0;
          end
        end
        S_STOP: begin
          if (tick_q == T_MIDP1) begin
            if (!vote_live) ferr_int_d = 1'b1;
            // Last stop bit closes the frame at mid-bit rather than end of
            // bit, leaving slack for a transmitter running slightly fast.
            if (bit_q == S_LAST) begin
              state_d = S_IDLE;
              tick_d  = '0;
              valid_d = 1'b1;
              data_d  = shift_q;
              perr_d  = perr_int_q;
              ferr_d  = ferr_now;
              armed_d = ~ferr_now;
            end
          end else if (tick_q == T_LAST) begin
            bit_d = bit_q + 4'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tick_q     <= '0;
      bit_q      <= '0;
      samp_q     <= '0;
      armed_q    <= 1'b0;
      shift_q    <= '0;
      data_q     <= '0;
      perr_int_q <= 1'b0;
      ferr_int_q <= 1'b0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      samp_q     <= samp_d;
      armed_q    <= armed_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      perr_int_q <= perr_int_d;
      ferr_int_q <= ferr_int_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Testbench for uart_rx_cfg: three configurations (8N1, 8E1, 7N2) driven by
// a bit-level transmitter; expected words and flags come from the bits sent.
module tb_uart_rx_cfg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic b_tick = 1'b0;
  logic rx_a = 1'b1, rx_p = 1'b1, rx_7 = 1'b1;

  logic [7:0] data_a, data_p;
  logic [6:0] data_7;
  logic valid_a, perr_a, ferr_a, busy_a;
  logic valid_p, perr_p, ferr_p, busy_p;
  logic valid_7, perr_7, ferr_7, busy_7;

  uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .rx(rx_a), .b_tick(b_tick), .rx_data(data_a), .rx_valid(valid_a),
    .parity_err(perr_a), .frame_err(ferr_a), .busy(busy_a));

  uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_p (
    .clk(clk), .rst(rst), .rx(rx_p), .b_tick(b_tick), .rx_data(data_p), .rx_valid(valid_p),
    .parity_err(perr_p), .frame_err(ferr_p), .busy(busy_p));

  uart_rx_cfg #(.DATA_BITS(7), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut_7 (
    .clk(clk), .rst(rst), .rx(rx_7), .b_tick(b_tick), .rx_data(data_7), .rx_valid(valid_7),
    .parity_err(perr_7), .frame_err(ferr_7), .busy(busy_7));

  typedef struct packed {
    logic [8:0] d;
    logic       p;
    logic       f;
  } rec_t;

  rec_t q_a[$];
  rec_t q_p[$];
  rec_t q_7[$];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (3) @(negedge clk);
      b_tick = 1'b1;
      @(negedge clk);
      b_tick = 1'b0;
    end
  end

  // Every cycle with rx_valid high is recorded, so a stretched pulse shows
  // up as an extra entry.
  always @(posedge clk) begin
    #1;
    if (valid_a) q_a.push_back({1'b0, data_a, perr_a, ferr_a});
    if (valid_p) q_p.push_back({1'b0, data_p, perr_p, ferr_p});
    if (valid_7) q_7.push_back({2'b0, data_7, perr_7, ferr_7});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int qsize(input int d);
    case (d)
      0:       return q_a.size();
      1:       return q_p.size();
      default: return q_7.size();
    endcase
  endfunction

  function automatic rec_t qpop(input int d);
    case (d)
      0:       return q_a.pop_front();
      1:       return q_p.pop_front();
      default: return q_7.pop_front();
    endcase
  endfunction

  function automatic logic get_busy(input int d);
    case (d)
      0:       return busy_a;
      1:       return busy_p;
      default: return busy_7;
    endcase
  endfunction

  task automatic set_rx(input int d, input logic v);
    case (d)
      0:       rx_a = v;
      1:       rx_p = v;
      default: rx_7 = v;
    endcase
  endtask

  task automatic hold(input int d, input logic v, input int clks);
    set_rx(d, v);
    repeat (clks) @(negedge clk);
  endtask

  // Drives one whole frame; glitch_bit selects a data bit that gets a
  // 4-clk inverted pulse near its centre (-1 for none).
  task automatic send_frame(input int d, input logic [8:0] data, input int nbits,
                            input int par_en, input logic pbit, input int nstop,
                            input logic sval, input int bclk, input int glitch_bit);
    hold(d, 1'b0, bclk);
    for (int i = 0; i < nbits; i++) begin
      if (i == glitch_bit) begin
        hold(d, data[i], bclk / 2 - 2);
        hold(d, ~data[i], 4);
        hold(d, data[i], bclk - bclk / 2 - 2);
      end else begin
        hold(d, data[i], bclk);
      end
    end
    if (par_en != 0) hold(d, pbit, bclk);
    for (int i = 0; i < nstop; i++) hold(d, sval, bclk);
  endtask

  // Reference rule: even/odd parity over the data bits actually sent.
  function automatic logic model_perr(input logic [8:0] data, input int nbits,
                                      input logic pbit, input logic odd);
    logic x;
    x = odd;
    for (int i = 0; i < nbits; i++) x ^= data[i];
    return pbit ^ x;
  endfunction

  task automatic expect_frame(input string tag, input int d, input logic [8:0] ed,
                              input logic ep, input logic ef);
    int   n;
    rec_t r;
    n = 0;
    while (qsize(d) == 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("%s_valid", tag), 32'(qsize(d) > 0), 32'd1);
    if (qsize(d) > 0) begin
      r = qpop(d);
      chk($sformatf("%s_data", tag), 32'(r.d), 32'(ed));
      chk($sformatf("%s_perr", tag), 32'(r.p), 32'(ep));
      chk($sformatf("%s_ferr", tag), 32'(r.f), 32'(ef));
    end
  endtask

  task automatic expect_quiet(input string tag, input int d);
    repeat (8) @(negedge clk);
    chk($sformatf("%s_extra_valid", tag), 32'(qsize(d)), 32'd0);
    chk($sformatf("%s_busy", tag), 32'(get_busy(d)), 32'd0);
    while (qsize(d) > 0) void'(qpop(d));
  endtask

  initial begin
    logic [8:0] dat;
    logic       pb;
    logic       sv;
    int         gl;

    repeat (5) @(negedge clk);
    chk("rst_data", 32'(data_a), 32'd0);
    chk("rst_valid", 32'(valid_a), 32'd0);
    chk("rst_perr", 32'(perr_a), 32'd0);
    chk("rst_ferr", 32'(ferr_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    rst = 1'b0;
    repeat (128) @(negedge clk);

    // 8N1 basic frame
    send_frame(0, 9'h0A5, 8, 0, 1'b0, 1, 1'b1, 64, -1);
    expect_frame("t1", 0, 9'h0A5, 1'b0, 1'b0);
    expect_quiet("t1", 0);

    // even parity: wrong then right parity bit
    send_frame(1, 9'h037, 8, 1, 1'b0, 1, 1'b1, 64, -1);
    expect_frame("t2a", 1, 9'h037, model_perr(9'h037, 8, 1'b0, 1'b0), 1'b0);
    expect_quiet("t2a", 1);
    send_frame(1, 9'h037, 8, 1, 1'b1, 1, 1'b1, 64, -1);
    expect_frame("t2b", 1, 9'h037, model_perr(9'h037, 8, 1'b1, 1'b0), 1'b0);
    expect_quiet("t2b", 1);

    // false start: 5 ticks low
    hold(0, 1'b0, 12);
    chk("t3_busy_hi", 32'(busy_a), 32'd1);
    hold(0, 1'b0, 8);
    hold(0, 1'b1, 128);
    expect_quiet("t3", 0);
    send_frame(0, 9'h05A, 8, 0, 1'b0, 1, 1'b1, 64, -1);
    expect_frame("t3b", 0, 9'h05A, 1'b0, 1'b0);
    expect_quiet("t3b", 0);

    // framing error then break
    send_frame(0, 9'h0FF, 8, 0, 1'b0, 1, 1'b0, 64, -1);
    hold(0, 1'b0, 3 * 10 * 64);
    expect_frame("t4", 0, 9'h0FF, 1'b0, 1'b1);
    expect_quiet("t4_break", 0);
    hold(0, 1'b1, 128);
    send_frame(0, 9'h011, 8, 0, 1'b0, 1, 1'b1, 64, -1);
    expect_frame("t4b", 0, 9'h011, 1'b0, 1'b0);
    expect_quiet("t4b", 0);

    // 7N2 back-to-back with a fast transmitter
    send_frame(2, 9'h001, 7, 0, 1'b0, 2, 1'b1, 62, -1);
    send_frame(2, 9'h07F, 7, 0, 1'b0, 2, 1'b1, 62, -1);
    send_frame(2, 9'h040, 7, 0, 1'b0, 2, 1'b1, 62, -1);
    expect_frame("t5a", 2, 9'h001, 1'b0, 1'b0);
    expect_frame("t5b", 2, 9'h07F, 1'b0, 1'b0);
    expect_frame("t5c", 2, 9'h040, 1'b0, 1'b0);
    expect_quiet("t5", 2);

    // reset mid-DATA of 0xC3 (bits LSB first: 1,1,0,0,...)
    hold(0, 1'b0, 64);
    hold(0, 1'b1, 64);
    hold(0, 1'b1, 64);
    hold(0, 1'b0, 32);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rx_a = 1'b1;
    chk("t6_data", 32'(data_a), 32'd0);
    chk("t6_valid", 32'(valid_a), 32'd0);
    chk("t6_perr", 32'(perr_a), 32'd0);
    chk("t6_ferr", 32'(ferr_a), 32'd0);
    chk("t6_busy", 32'(busy_a), 32'd0);
    hold(0, 1'b1, 128);
    expect_quiet("t6", 0);
    send_frame(0, 9'h03C, 8, 0, 1'b0, 1, 1'b1, 64, -1);
    expect_frame("t6b", 0, 9'h03C, 1'b0, 1'b0);
    expect_quiet("t6b", 0);

    // random 8N1 frames, occasional bad stop bit and data glitch
    for (int k = 0; k < 6; k++) begin
      dat = 9'($urandom_range(0, 255));
      sv  = ($urandom_range(0, 3) != 0);
      gl  = int'($urandom_range(0, 8)) - 1;
      send_frame(0, dat, 8, 0, 1'b0, 1, sv, 64, gl);
      hold(0, 1'b1, 64);
      expect_frame($sformatf("rnd_a%0d", k), 0, dat, 1'b0, ~sv);
      expect_quiet($sformatf("rnd_a%0d", k), 0);
    end

    // random 8E1 frames with random parity bit
    for (int k = 0; k < 6; k++) begin
      dat = 9'($urandom_range(0, 255));
      pb  = 1'($urandom_range(0, 1));
      gl  = int'($urandom_range(0, 8)) - 1;
      send_frame(1, dat, 8, 1, pb, 1, 1'b1, 64, gl);
      hold(1, 1'b1, 16);
      expect_frame($sformatf("rnd_p%0d", k), 1, dat, model_perr(dat, 8, pb, 1'b0), 1'b0);
      expect_quiet($sformatf("rnd_p%0d", k), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
